// File: rtl/top_ahb_if.sv
// Bus-side signal bundle for top_ahb: master-driven request fields plus the
// registered read data and the latched internal data-phase bus for observation.
interface top_ahb_if;
  logic        enable;
  logic [31:0] in_hwdata;
  logic [31:0] in_haddr;
  logic [2:0]  in_hsize;
  logic [2:0]  in_hburst;
  logic [1:0]  in_hsel;
  logic        in_hwrite;
  logic [1:0]  in_htrans;
  logic [31:0] out_hrdata;

  // Internal bus as seen by the slaves during the data phase.
  logic [31:0] bus_haddr;
  logic [1:0]  bus_hsel;
  logic        bus_hwrite;
  logic [2:0]  bus_hsize;
  logic [2:0]  bus_hburst;
  logic        bus_hready;
  logic        bus_hresp;

  modport master (
    output enable, in_hwdata, in_haddr, in_hsize, in_hburst, in_hsel, in_hwrite, in_htrans,
    input  out_hrdata, bus_haddr, bus_hsel, bus_hwrite, bus_hsize, bus_hburst, bus_hready, bus_hresp
  );

  modport slave (
    input  enable, in_hwdata, in_haddr, in_hsize, in_hburst, in_hsel, in_hwrite, in_htrans,
    output out_hrdata, bus_haddr, bus_hsel, bus_hwrite, bus_hsize, bus_hburst, bus_hready, bus_hresp
  );
endinterface

// File: rtl/top_ahb.sv
// Single AHB master driving four zero-wait 16x32 memory slaves with pipelined
// address/data phases, burst address generation and a registered read-data mux.
module top_ahb (
  input logic      clk,
  input logic      hresetn,
  top_ahb_if.slave bus
);
  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_WRAP4  = 3'b010;

  logic [31:0] mem [4][16];
  logic [31:0] addr_q;
  logic [31:0] next_addr;
  logic [31:0] rd_word;
  logic [31:0] hrdata_q;
  logic        beat_seen_q;
  logic        dp_valid_q;
  logic        dp_write_q;
  logic [1:0]  dp_sel_q;
  logic [2:0]  dp_size_q;
  logic [2:0]  dp_burst_q;
  logic        addr_active;
  htrans_e     trans;

  always_comb begin
    trans       = htrans_e'(bus.in_htrans);
    addr_active = bus.enable && (trans == TR_NONSEQ || trans == TR_SEQ);
    next_addr   = bus.in_haddr;
    // A SEQ continues from the last active beat; with no prior beat it acts as NONSEQ.
    if (trans == TR_SEQ && beat_seen_q) begin
      case (bus.in_hburst)
        BURST_SINGLE: next_addr = addr_q;
        BURST_WRAP4:  next_addr = {addr_q[31:2], addr_q[1:0] + 2'd1};
        default:      next_addr = addr_q + 32'd1;
      endcase
    end
    rd_word = mem[dp_sel_q][addr_q[3:0]];
  end

  // NOTE: the memory is built from resettable flops because every word must read
  // as zero after reset; an SRAM macro could not be cleared in one cycle.
  always_ff @(posedge clk) begin
    if (hresetn) begin
      for (int s = 0; s < 4; s++) begin
        for (int w = 0; w < 16; w++) begin
          mem[s][w] <= '0;
        end
      end
      hrdata_q    <= '0;
      addr_q      <= '0;
      beat_seen_q <= 1'b0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_sel_q    <= '0;
      dp_size_q   <= '0;
      dp_burst_q  <= '0;
    end else begin
      // NOTE: non-blocking updates let the data phase use the old addr_q while
      // the overlapping address phase loads the next one on the same edge.
      if (dp_valid_q) begin
        if (dp_write_q) mem[dp_sel_q][addr_q[3:0]] <= bus.in_hwdata;
        else            hrdata_q                   <= rd_word;
      end
      dp_valid_q <= addr_active;
      if (addr_active) begin
        addr_q      <= next_addr;
        beat_seen_q <= 1'b1;
        dp_write_q  <= bus.in_hwrite;
        dp_sel_q    <= bus.in_hsel;
        dp_size_q   <= bus.in_hsize;
        dp_burst_q  <= bus.in_hburst;
      end
    end
  end

  assign bus.out_hrdata = hrdata_q;
  assign bus.bus_haddr  = addr_q;
  assign bus.bus_hsel   = dp_sel_q;
  assign bus.bus_hwrite = dp_write_q;
  assign bus.bus_hsize  = dp_size_q;
  assign bus.bus_hburst = dp_burst_q;
  assign bus.bus_hready = 1'b1;
  assign bus.bus_hresp  = 1'b0;
endmodule

// File: tb/tb_top_ahb.sv
// Directed bench for top_ahb: each scenario task drives bus beats and compares
// out_hrdata against hand-computed values.
module tb_top_ahb;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001, WRAP4 = 3'b010;

  logic clk = 1'b0;
  logic hresetn;
  int   n_tests = 0;
  int   n_fail  = 0;

  top_ahb_if bus_if ();

  top_ahb u_dut (
    .clk     (clk),
    .hresetn (hresetn),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  // One bus cycle: present inputs, take the rising edge, settle 1 time unit.
  task automatic drive(input logic en, input logic [1:0] tr, input logic [31:0] a,
                       input logic [2:0] b, input logic [1:0] s, input logic w,
                       input logic [31:0] wd);
    bus_if.enable    = en;
    bus_if.in_htrans = tr;
    bus_if.in_haddr  = a;
    bus_if.in_hburst = b;
    bus_if.in_hsel   = s;
    bus_if.in_hwrite = w;
    bus_if.in_hwdata = wd;
    bus_if.in_hsize  = 3'b010;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] wd);
    drive(1'b1, IDLE, 32'h0, SINGLE, 2'd0, 1'b0, wd);
  endtask

  task automatic wr(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, NONSEQ, a, SINGLE, s, 1'b1, 32'h0);
    idle(d);
  endtask

  task automatic rd(input logic [1:0] s, input logic [31:0] a, output logic [31:0] d);
    drive(1'b1, NONSEQ, a, SINGLE, s, 1'b0, 32'h0);
    idle(32'h0);
    d = bus_if.out_hrdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    hresetn = 1'b1;
    idle(32'h0);
    idle(32'h0);
    hresetn = 1'b0;
    n_tests++; if (bus_if.out_hrdata !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata got %h want %h", bus_if.out_hrdata, 32'h0); end
    wr(2'd0, 32'd1, 32'h1234);
    rd(2'd0, 32'd1, d);
    n_tests++; if (d !== 32'h1234) begin n_fail++; $display("FAIL pre_reset_rd got %h want %h", d, 32'h1234); end
    hresetn = 1'b1;
    idle(32'h0);
    hresetn = 1'b0;
    n_tests++; if (bus_if.out_hrdata !== 32'h0) begin n_fail++; $display("FAIL reset_clears_hrdata got %h want %h", bus_if.out_hrdata, 32'h0); end
    // First beat after reset is a SEQ: must be taken as NONSEQ at addr 2.
    drive(1'b1, SEQ, 32'd2, INCR, 2'd0, 1'b1, 32'h0);
    idle(32'h99);
    rd(2'd0, 32'd1, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_then_read got %h want %h", d, 32'h0); end
    rd(2'd0, 32'd2, d);
    n_tests++; if (d !== 32'h99) begin n_fail++; $display("FAIL seq_as_nonseq got %h want %h", d, 32'h99); end
  endtask

  task automatic test_incr();
    drive(1'b1, NONSEQ, 32'd1, INCR, 2'd0, 1'b1, 32'h0);
    drive(1'b1, SEQ, 32'hFFFF, INCR, 2'd0, 1'b1, 32'd1);
    drive(1'b1, SEQ, 32'hFFFF, INCR, 2'd0, 1'b1, 32'd2);
    drive(1'b1, SEQ, 32'hFFFF, INCR, 2'd0, 1'b1, 32'd3);
    idle(32'd4);
    drive(1'b1, NONSEQ, 32'd1, INCR, 2'd0, 1'b0, 32'h0);
    drive(1'b1, SEQ, 32'h0, INCR, 2'd0, 1'b0, 32'h0);
    n_tests++; if (bus_if.out_hrdata !== 32'd1) begin n_fail++; $display("FAIL incr_rd0 got %h want %h", bus_if.out_hrdata, 32'd1); end
    drive(1'b1, SEQ, 32'h0, INCR, 2'd0, 1'b0, 32'h0);
    n_tests++; if (bus_if.out_hrdata !== 32'd2) begin n_fail++; $display("FAIL incr_rd1 got %h want %h", bus_if.out_hrdata, 32'd2); end
    drive(1'b1, SEQ, 32'h0, INCR, 2'd0, 1'b0, 32'h0);
    n_tests++; if (bus_if.out_hrdata !== 32'd3) begin n_fail++; $display("FAIL incr_rd2 got %h want %h", bus_if.out_hrdata, 32'd3); end
    idle(32'h0);
    n_tests++; if (bus_if.out_hrdata !== 32'd4) begin n_fail++; $display("FAIL incr_rd3 got %h want %h", bus_if.out_hrdata, 32'd4); end
    idle(32'h0);
    n_tests++; if (bus_if.out_hrdata !== 32'd4) begin n_fail++; $display("FAIL hrdata_hold got %h want %h", bus_if.out_hrdata, 32'd4); end
  endtask

  task automatic test_wrap4();
    logic [31:0] d;
    logic [31:0] exp_val [4] = '{32'hA, 32'hB, 32'hC, 32'hD};
    logic [31:0] exp_addr [4] = '{32'd6, 32'd7, 32'd4, 32'd5};
    drive(1'b1, NONSEQ, 32'd6, WRAP4, 2'd0, 1'b1, 32'h0);
    drive(1'b1, SEQ, 32'h0, WRAP4, 2'd0, 1'b1, 32'hA);
    drive(1'b1, SEQ, 32'h0, WRAP4, 2'd0, 1'b1, 32'hB);
    drive(1'b1, SEQ, 32'h0, WRAP4, 2'd0, 1'b1, 32'hC);
    idle(32'hD);
    for (int i = 0; i < 4; i++) begin
      rd(2'd0, exp_addr[i], d);
      n_tests++; if (d !== exp_val[i]) begin n_fail++; $display("FAIL wrap4_word%0d got %h want %h", exp_addr[i], d, exp_val[i]); end
    end
  endtask

  task automatic test_isolation();
    logic [31:0] d;
    wr(2'd2, 32'd3, 32'hDEADBEEF);
    rd(2'd1, 32'd3, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL iso_sel1 got %h want %h", d, 32'h0); end
    rd(2'd3, 32'd3, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL iso_sel3 got %h want %h", d, 32'h0); end
    rd(2'd2, 32'd3, d);
    n_tests++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL iso_sel2 got %h want %h", d, 32'hDEADBEEF); end
  endtask

  task automatic test_idle_busy_enable();
    logic [31:0] d;
    // Write burst on slave 3 with a BUSY beat and a disabled cycle in the middle.
    drive(1'b1, NONSEQ, 32'd8, INCR, 2'd3, 1'b1, 32'h0);
    drive(1'b1, SEQ, 32'h0, INCR, 2'd3, 1'b1, 32'h11);
    drive(1'b1, BUSY, 32'h0, INCR, 2'd3, 1'b1, 32'h22);
    drive(1'b0, SEQ, 32'h0, INCR, 2'd3, 1'b1, 32'hBAD0);
    drive(1'b1, SEQ, 32'h0, INCR, 2'd3, 1'b1, 32'hBAD1);
    idle(32'h33);
    n_tests++; if (bus_if.out_hrdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_keeps_hrdata got %h want %h", bus_if.out_hrdata, 32'hDEADBEEF); end
    // Same pattern as a read burst, checking hold during BUSY/disable.
    drive(1'b1, NONSEQ, 32'd8, INCR, 2'd3, 1'b0, 32'h0);
    drive(1'b1, SEQ, 32'h0, INCR, 2'd3, 1'b0, 32'h0);
    n_tests++; if (bus_if.out_hrdata !== 32'h11) begin n_fail++; $display("FAIL busy_rd8 got %h want %h", bus_if.out_hrdata, 32'h11); end
    drive(1'b1, BUSY, 32'h0, INCR, 2'd3, 1'b0, 32'h0);
    n_tests++; if (bus_if.out_hrdata !== 32'h22) begin n_fail++; $display("FAIL busy_rd9 got %h want %h", bus_if.out_hrdata, 32'h22); end
    drive(1'b0, SEQ, 32'h0, INCR, 2'd3, 1'b0, 32'h0);
    n_tests++; if (bus_if.out_hrdata !== 32'h22) begin n_fail++; $display("FAIL busy_hold got %h want %h", bus_if.out_hrdata, 32'h22); end
    drive(1'b1, SEQ, 32'h0, INCR, 2'd3, 1'b0, 32'h0);
    n_tests++; if (bus_if.out_hrdata !== 32'h22) begin n_fail++; $display("FAIL disable_hold got %h want %h", bus_if.out_hrdata, 32'h22); end
    // Enable drops while the last data phase is pending: it must still complete.
    drive(1'b0, IDLE, 32'h0, INCR, 2'd3, 1'b0, 32'h0);
    n_tests++; if (bus_if.out_hrdata !== 32'h33) begin n_fail++; $display("FAIL resume_rd10 got %h want %h", bus_if.out_hrdata, 32'h33); end
    rd(2'd3, 32'd11, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL no_skip_word11 got %h want %h", d, 32'h0); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, NONSEQ, 32'd9, SINGLE, 2'd0, 1'b1, 32'h0);
    drive(1'b1, NONSEQ, 32'd9, SINGLE, 2'd0, 1'b0, 32'h55);
    idle(32'h0);
    n_tests++; if (bus_if.out_hrdata !== 32'h55) begin n_fail++; $display("FAIL wr_rd_hazard got %h want %h", bus_if.out_hrdata, 32'h55); end
  endtask

  task automatic test_addr_wrap32();
    logic [31:0] d;
    drive(1'b1, NONSEQ, 32'hFFFF_FFFF, INCR, 2'd1, 1'b1, 32'h0);
    drive(1'b1, SEQ, 32'h0, INCR, 2'd1, 1'b1, 32'h77);
    idle(32'h88);
    rd(2'd1, 32'd15, d);
    n_tests++; if (d !== 32'h77) begin n_fail++; $display("FAIL wrap32_word15 got %h want %h", d, 32'h77); end
    rd(2'd1, 32'd0, d);
    n_tests++; if (d !== 32'h88) begin n_fail++; $display("FAIL wrap32_word0 got %h want %h", d, 32'h88); end
  endtask

  task automatic test_single_seq();
    logic [31:0] d;
    // SINGLE-coded SEQ holds the address: second beat overwrites word 12.
    drive(1'b1, NONSEQ, 32'd12, SINGLE, 2'd1, 1'b1, 32'h0);
    drive(1'b1, SEQ, 32'h0, SINGLE, 2'd1, 1'b1, 32'h1);
    idle(32'h2);
    rd(2'd1, 32'd12, d);
    n_tests++; if (d !== 32'h2) begin n_fail++; $display("FAIL single_hold12 got %h want %h", d, 32'h2); end
    rd(2'd1, 32'd13, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL single_no13 got %h want %h", d, 32'h0); end
  endtask

  initial begin
    hresetn = 1'b1;
    bus_if.enable    = 1'b0;
    bus_if.in_htrans = IDLE;
    bus_if.in_haddr  = '0;
    bus_if.in_hburst = SINGLE;
    bus_if.in_hsel   = '0;
    bus_if.in_hwrite = 1'b0;
    bus_if.in_hwdata = '0;
    bus_if.in_hsize  = 3'b010;
    test_reset();
    test_incr();
    test_wrap4();
    test_isolation();
    test_idle_busy_enable();
    test_back_to_back();
    test_addr_wrap32();
    test_single_seq();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
